// File: rtl/core_pkg.sv
// ============================================================================
// Module      : core_pkg
// Description : Shared core constants and instruction class encodings.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package core_pkg;

    localparam int c_INSTR_WIDTH = 32;
    localparam int c_QUEUE_DEPTH = 16;

    // Instruction class occupies the top nibble; the stage-1 decoder fans out on it.
    localparam int c_CLASS_MSB = 31;
    localparam int c_CLASS_LSB = 28;

    typedef enum logic [3:0] {
        CLS_NOP    = 4'h0,
        CLS_DMA    = 4'h1,
        CLS_DCACHE = 4'h2,
        CLS_MATH   = 4'h3
    } instr_class_e;

    function automatic instr_class_e instr_class(input logic [c_INSTR_WIDTH-1:0] word);
        return instr_class_e'(word[c_CLASS_MSB:c_CLASS_LSB]);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_ram.sv
// ============================================================================
// Module      : fifo_ram
// Description : Simple dual-port synchronous RAM with registered read port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_ram #(
    parameter  int DEPTH       = 16,
    parameter  int INSTR_WIDTH = 32,
    localparam int ADDR_W      = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   i_wr_en,
    input  logic [ADDR_W-1:0]      i_wr_addr,
    input  logic [INSTR_WIDTH-1:0] i_wr_data,
    input  logic [ADDR_W-1:0]      i_rd_addr,
    output logic [INSTR_WIDTH-1:0] o_rd_data
);

    logic [INSTR_WIDTH-1:0] r_mem [DEPTH];
    logic [INSTR_WIDTH-1:0] r_rd_data;

    // Write-first on an address collision so a word written this edge is what the head sees.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_wr_en && (i_wr_addr == i_rd_addr)) begin
            r_rd_data <= i_wr_data;
        end else begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

`default_nettype wire

// File: rtl/instr_issue_queue.sv
// ============================================================================
// Module      : instr_issue_queue
// Description : Instruction FIFO with freeze-aware registered issue stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_issue_queue
    import core_pkg::*;
#(
    parameter  int DEPTH       = c_QUEUE_DEPTH,
    parameter  int INSTR_WIDTH = c_INSTR_WIDTH,
    parameter  int CNT_W       = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   flush,
    input  logic                   wr_valid,
    input  logic [INSTR_WIDTH-1:0] wr_data,
    output logic                   wr_ready,
    input  logic                   freeze,
    output logic                   rd_valid,
    output logic [INSTR_WIDTH-1:0] rd_data,
    output logic                   empty,
    output logic                   full,
    output logic [CNT_W-1:0]       count,
    output logic                   err_overflow
);

    localparam int             c_PTR_W    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] c_FULL_CNT = CNT_W'(DEPTH);

    logic [c_PTR_W-1:0]     r_wr_ptr;
    logic [c_PTR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]       r_count;
    logic                   r_rd_valid;
    logic [INSTR_WIDTH-1:0] r_rd_data;
    logic                   r_err_overflow;

    logic                   w_empty;
    logic                   w_full;
    logic                   w_push;
    logic                   w_pop;
    logic [c_PTR_W-1:0]     w_rd_ptr_nxt;
    logic [INSTR_WIDTH-1:0] w_ram_q;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_FULL_CNT);
    assign w_push  = wr_valid && !w_full && !flush;
    assign w_pop   = !freeze && !w_empty && !flush;

    // RAM reads the pointer the head will have after this edge, so the head is ready at pop time.
    always_comb begin
        w_rd_ptr_nxt = r_rd_ptr;
        if (flush) begin
            w_rd_ptr_nxt = '0;
        end else if (w_pop) begin
            w_rd_ptr_nxt = r_rd_ptr + c_PTR_W'(1);
        end
    end

    fifo_ram #(
        .DEPTH       (DEPTH),
        .INSTR_WIDTH (INSTR_WIDTH)
    ) u_fifo_ram (
        .clk       (clk),
        .i_wr_en   (w_push),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (wr_data),
        .i_rd_addr (w_rd_ptr_nxt),
        .o_rd_data (w_ram_q)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_err_overflow <= 1'b0;
        end else if (flush) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_err_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            r_rd_ptr <= w_rd_ptr_nxt;
            r_count  <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            if (wr_valid && w_full) begin
                r_err_overflow <= 1'b1;
            end
        end
    end

    // Issue register: stage 0 of the pipeline, so freeze holds it exactly.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else if (flush) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else if (w_pop) begin
            r_rd_valid <= 1'b1;
            r_rd_data  <= w_ram_q;
        end else if (!freeze) begin
            r_rd_valid <= 1'b0;
        end
    end

    assign wr_ready     = !w_full;
    assign empty        = w_empty;
    assign full         = w_full;
    assign count        = r_count;
    assign rd_valid     = r_rd_valid;
    assign rd_data      = r_rd_data;
    assign err_overflow = r_err_overflow;

endmodule

`default_nettype wire

// File: tb/tb_instr_issue_queue.sv
// ============================================================================
// Module      : tb_instr_issue_queue
// Description : Self-checking bench with a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_issue_queue;

    localparam int DEPTH = 4;
    localparam int W     = 32;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk     = 1'b0;
    logic          reset_n = 1'b1;
    logic          flush   = 1'b0;
    logic          wr_valid = 1'b0;
    logic [W-1:0]  wr_data = '0;
    logic          freeze  = 1'b0;
    logic          wr_ready;
    logic          rd_valid;
    logic [W-1:0]  rd_data;
    logic          empty;
    logic          full;
    logic [CW-1:0] count;
    logic          err_overflow;

    int nerr = 0;
    int nchk = 0;
    bit cmp_en = 1'b0;

    instr_issue_queue #(
        .DEPTH       (DEPTH),
        .INSTR_WIDTH (W)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .flush        (flush),
        .wr_valid     (wr_valid),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .freeze       (freeze),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .empty        (empty),
        .full         (full),
        .count        (count),
        .err_overflow (err_overflow)
    );

    always #5 clk = ~clk;

    // Reference model: a plain queue plus the issue register and sticky flag.
    logic [W-1:0] mq[$];
    logic         m_valid;
    logic [W-1:0] m_data;
    logic         m_err;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mq.delete();
            m_valid = 1'b0;
            m_data  = '0;
            m_err   = 1'b0;
        end else if (flush) begin
            mq.delete();
            m_valid = 1'b0;
            m_data  = '0;
            m_err   = 1'b0;
        end else begin
            bit do_push;
            do_push = wr_valid && (mq.size() < DEPTH);
            if (wr_valid && mq.size() == DEPTH) m_err = 1'b1;
            if (!freeze && mq.size() > 0) begin
                m_data  = mq.pop_front();
                m_valid = 1'b1;
            end else if (!freeze) begin
                m_valid = 1'b0;
            end
            if (do_push) mq.push_back(wr_data);
        end
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("m_count",    W'(count),        W'(mq.size()));
            check("m_empty",    W'(empty),        W'(mq.size() == 0));
            check("m_full",     W'(full),         W'(mq.size() == DEPTH));
            check("m_wr_ready", W'(wr_ready),     W'(mq.size() != DEPTH));
            check("m_err",      W'(err_overflow), W'(m_err));
            check("m_valid",    W'(rd_valid),     W'(m_valid));
            if (m_valid) check("m_data", rd_data, m_data);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_count"},    W'(count),        '0);
        check({tag, "_empty"},    W'(empty),        W'(1));
        check({tag, "_full"},     W'(full),         '0);
        check({tag, "_wr_ready"}, W'(wr_ready),     W'(1));
        check({tag, "_rd_valid"}, W'(rd_valid),     '0);
        check({tag, "_rd_data"},  rd_data,          '0);
        check({tag, "_err"},      W'(err_overflow), '0);
    endtask

    initial begin
        // Reset, then three words through with no freeze
        #1 reset_n = 1'b0;
        #2 check_reset_outputs("rst");
        tick();
        tick();
        reset_n  = 1'b1;
        cmp_en   = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 32'h11;
        tick();
        check("fill_lat_valid", W'(rd_valid), '0);
        check("fill_lat_count", W'(count), W'(1));
        wr_data = 32'h22;
        tick();
        check("fill_w0", rd_data, 32'h11);
        check("fill_v0", W'(rd_valid), W'(1));
        wr_data = 32'h33;
        tick();
        check("fill_w1", rd_data, 32'h22);
        wr_valid = 1'b0;
        tick();
        check("fill_w2", rd_data, 32'h33);
        check("fill_cnt0", W'(count), '0);
        tick();
        check("fill_bubble", W'(rd_valid), '0);
        check("fill_empty", W'(empty), W'(1));

        // Full and overflow under freeze
        freeze = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wr_valid = 1'b1;
            wr_data  = 32'hA0 + i;
            tick();
            if (i == 3) begin
                check("ovf_full", W'(full), W'(1));
                check("ovf_ready", W'(wr_ready), '0);
                check("ovf_cnt", W'(count), W'(4));
                check("ovf_err_pre", W'(err_overflow), '0);
            end
        end
        check("ovf_err", W'(err_overflow), W'(1));
        check("ovf_cnt_hold", W'(count), W'(4));
        wr_valid = 1'b0;
        freeze   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("ovf_drain", rd_data, 32'hA0 + i);
        end
        tick();
        check("ovf_drained", W'(rd_valid), '0);

        // Freeze hold with an issued 0xAB
        wr_valid = 1'b1;
        wr_data  = 32'hAB;
        tick();
        wr_valid = 1'b0;
        tick();
        check("frz_ab", rd_data, 32'hAB);
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1;
            wr_data  = 32'hC1 + i;
            tick();
            check("frz_data", rd_data, 32'hAB);
            check("frz_valid", W'(rd_valid), W'(1));
            check("frz_cnt", W'(count), W'(i + 1));
        end
        wr_data = 32'hC4;
        tick();
        wr_data = 32'hC5;
        tick();
        check("frz_err", W'(err_overflow), W'(1));
        wr_valid = 1'b0;
        freeze   = 1'b0;
        tick();
        check("frz_pop", rd_data, 32'hC1);
        check("frz_cnt3", W'(count), W'(3));

        // Flush with a concurrent write
        flush    = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 32'hEE;
        tick();
        check("fl_cnt", W'(count), '0);
        check("fl_valid", W'(rd_valid), '0);
        check("fl_err", W'(err_overflow), '0);
        flush    = 1'b0;
        wr_valid = 1'b0;
        tick();
        check("fl_nostore", W'(rd_valid), '0);
        check("fl_nostore_cnt", W'(count), '0);

        // Wrap-around streaming, one in and one out per cycle
        for (int i = 0; i <= 10; i++) begin
            wr_valid = (i < 10);
            wr_data  = 32'h100 + i;
            tick();
            check("wrap_cnt_le1", W'(count <= 1), W'(1));
            if (i >= 1) check("wrap_data", rd_data, 32'h100 + i - 1);
        end

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            wr_valid = ($urandom_range(0, 3) != 0);
            wr_data  = $urandom;
            freeze   = ($urandom_range(0, 2) == 0);
            flush    = ($urandom_range(0, 60) == 0);
            tick();
        end
        flush  = 1'b0;
        freeze = 1'b1;

        // Asynchronous reset mid-stream, between edges
        wr_valid = 1'b1;
        wr_data  = 32'h5A5A;
        tick();
        tick();
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1 check_reset_outputs("arst");
        wr_valid = 1'b0;
        freeze   = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/instr_issue_queue.md
Name: instr_issue_queue

Overview:
- Parametrised instruction FIFO that feeds the stage-1 fan-out (DMA, dcache, math) from a loader such as the UART program loader.
- Provides real storage depth, backpressure, occupancy, flush and overflow reporting.
- Presents a registered head-of-queue output that honours the global freeze, so it behaves as pipeline stage 0.

Parameters:
- DEPTH, 16, number of entries. Power of two, at least 2.
- INSTR_WIDTH, 32, bits per instruction word.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count. Derived; do not override.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous queue clear
- wr_valid  in  1  loader presents a word
- wr_data  in  INSTR_WIDTH  instruction word from the loader
- wr_ready  out  1  queue can accept a word; equals !full
- freeze  in  1  global pipeline freeze (DMA busy)
- rd_valid  out  1  rd_data holds an issued instruction
- rd_data  out  INSTR_WIDTH  issued instruction (stage-1 input)
- empty  out  1  storage holds no entries
- full  out  1  storage holds DEPTH entries
- count  out  CNT_W  entries in storage, excluding the output register
- err_overflow  out  1  sticky flag: a write was attempted while full

Behaviour:
- Reset: asynchronous on reset_n low.
  - Read and write pointers = 0, count = 0, rd_valid = 0, rd_data = 0, err_overflow = 0.
  - Hence empty = 1, full = 0, wr_ready = 1.
- Storage: circular buffer, pointers $clog2(DEPTH) bits wide, natural wrap from DEPTH-1 to 0.
- Status signals: empty = (count == 0) and full = (count == DEPTH), both decoded combinationally from the count register.
- Push: occurs when wr_valid && !full && !flush. The word is written at the write pointer and the write pointer increments.
- Push while full: the word is dropped, and err_overflow is set on the next edge.
- Pop: occurs when !freeze && !empty && !flush. The head entry is loaded into rd_data, rd_valid is set to 1, and the read pointer increments.
- Output register, no pop:
  - !freeze && empty: rd_valid goes to 0 (bubble). rd_data keeps its last value (don't-care).
  - freeze = 1: rd_valid and rd_data are held unchanged, and no pop occurs regardless of occupancy.
- Push and pop in the same cycle: count is unchanged.
  - When full, push is blocked even if a pop occurs that cycle; there is no same-cycle slot reuse.
  - When empty, only the push takes effect.
- No bypass: a word written at edge t is in storage after t. The earliest pop is edge t+1, so rd_valid is first seen high after edge t+1 (2-edge write-to-issue latency).
- Flush: highest priority over push and pop.
  - Next edge: pointers = 0, count = 0, rd_valid = 0, err_overflow = 0.
  - A simultaneous wr_valid is discarded and does not set the overflow flag.
- Freeze and flush together: flush wins, and the output register is cleared.
- Reset mid-operation: all contents are lost. No partial state survives.
- Arithmetic: count is updated as count + push - pop in CNT_W bits and never exceeds DEPTH by construction.
- The downstream consumer must treat rd_data as meaningful only when rd_valid = 1.

Decomposition:
- Shared package (core_pkg) holds:
  - INSTR_WIDTH default constant
  - instruction class field position and encodings used by the downstream decoder
  - QUEUE_DEPTH default
- Sub-module: fifo_ram, a simple dual-port synchronous RAM parametrised by DEPTH and INSTR_WIDTH.
  - Keeps BRAM inference clean.
  - Read address is driven by the next read pointer so the head is available on the pop edge.
- Pointers, count, flags and the output register live in instr_issue_queue.

Test Plan:
- Reset then fill: hold reset_n low, release, then push 0x11, 0x22, 0x33 with freeze = 0 -> rd_valid pulses carry 0x11, 0x22, 0x33 in order; the first arrives 2 edges after its push; count returns to 0; empty = 1.
- Full and overflow (DEPTH = 4, freeze = 1): push 5 words -> after 4 pushes full = 1, wr_ready = 0, count = 4; the 5th is dropped and err_overflow = 1. Release freeze -> exactly the 4 words issue, in order.
- Freeze hold: with rd_valid = 1 and rd_data = 0xAB, hold freeze for 3 cycles while pushing -> rd_data stays 0xAB, rd_valid stays 1, and count increments by the number of pushes.
- Wrap-around (DEPTH = 4): stream 10 words, pushing 1 and popping 1 per cycle -> all 10 issue in order with no loss, and count never exceeds 1.
- Flush: with count = 3, rd_valid = 1 and err_overflow = 1, assert flush together with wr_valid -> next cycle count = 0, rd_valid = 0, err_overflow = 0, and the concurrent word is not stored.
- Asynchronous reset: drop reset_n mid-stream, between clock edges -> outputs reach their reset values immediately, with no clock edge required.
